// File: rtl/threshold_ctrl.sv
// threshold_ctrl: frame sequencer for the Canny back end. Starts the
// double-threshold stage with frame-stable thresholds, chains into the
// hysteresis stage, acknowledges the frame upstream, and owns the
// programmable HIGH/LOW registers, a per-stage watchdog and a frame counter.
module threshold_ctrl #(
   parameter int unsigned PIX_WIDTH = 8,
   parameter int unsigned DEF_HIGH  = 100,
   parameter int unsigned DEF_LOW   = 50,
   parameter int unsigned TIMEOUT   = 1048576,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_wr,
   input  logic                 cfg_sel,
   input  logic [PIX_WIDTH-1:0] cfg_data,
   output logic                 cfg_err,
   input  logic                 thin_val,
   output logic                 thin_ack,
   output logic                 dt_start,
   output logic [PIX_WIDTH-1:0] dt_high,
   output logic [PIX_WIDTH-1:0] dt_low,
   input  logic                 dual_val,
   output logic                 hyst_start,
   input  logic                 hyst_done,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] frame_cnt,
   output logic                 timeout_err
);

   localparam int unsigned WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned ST_WIDTH = 3;

   localparam logic [ST_WIDTH-1:0] S_IDLE     = 3'd0;
   localparam logic [ST_WIDTH-1:0] S_START_DT = 3'd1;
   localparam logic [ST_WIDTH-1:0] S_WAIT_DT  = 3'd2;
   localparam logic [ST_WIDTH-1:0] S_START_HY = 3'd3;
   localparam logic [ST_WIDTH-1:0] S_WAIT_HY  = 3'd4;
   localparam logic [ST_WIDTH-1:0] S_DONE     = 3'd5;

   logic [ST_WIDTH-1:0]  r_state;
   logic [ST_WIDTH-1:0]  w_next;
   logic                 w_timeout;
   logic                 w_dt_start;
   logic                 w_hyst_start;
   logic                 w_thin_ack;
   logic                 w_busy;
   logic                 w_latch;
   logic                 w_wd_clr;
   logic                 w_wd_run;
   logic                 w_count;

   logic                 r_dual_q;
   logic                 w_dual_rise;
   logic [WD_WIDTH-1:0]  r_wd_cnt;
   logic                 w_wd_expired;
   logic                 r_drop;

   logic [PIX_WIDTH-1:0] r_act_high;
   logic [PIX_WIDTH-1:0] r_act_low;
   logic                 w_cfg_ok;

   assign w_dual_rise  = dual_val & ~r_dual_q;
   assign w_wd_expired = (r_wd_cnt == WD_WIDTH'(TIMEOUT - 1));
   assign w_cfg_ok     = cfg_sel ? (cfg_data >= r_act_low) : (cfg_data <= r_act_high);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; the awaited event wins over a coincident watchdog expiry
   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (thin_val) w_next = S_START_DT;
         end
         S_START_DT: w_next = S_WAIT_DT;
         S_WAIT_DT: begin
            if (w_dual_rise) begin
               w_next = S_START_HY;
            end else if (w_wd_expired) begin
               w_next    = S_DONE;
               w_timeout = 1'b1;
            end
         end
         S_START_HY: w_next = S_WAIT_HY;
         S_WAIT_HY: begin
            if (hyst_done) begin
               w_next = S_DONE;
            end else if (w_wd_expired) begin
               w_next    = S_DONE;
               w_timeout = 1'b1;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode from the next state so the registered pulses line up with the state
   always_comb begin
      w_dt_start   = 1'b0;
      w_hyst_start = 1'b0;
      w_thin_ack   = 1'b0;
      w_busy       = 1'b0;
      w_latch      = 1'b0;
      w_wd_clr     = 1'b0;
      w_wd_run     = 1'b0;
      w_count      = 1'b0;
      w_dt_start   = (w_next == S_START_DT);
      w_hyst_start = (w_next == S_START_HY);
      w_thin_ack   = (w_next == S_DONE);
      w_busy       = (w_next != S_IDLE);
      w_latch      = (r_state == S_IDLE) && (w_next == S_START_DT);
      w_wd_clr     = (r_state == S_START_DT) || (r_state == S_START_HY);
      w_wd_run     = (r_state == S_WAIT_DT) || (r_state == S_WAIT_HY);
      w_count      = (r_state == S_DONE) && !r_drop;
   end

   // Registered handshake and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         dt_start   <= 1'b0;
         hyst_start <= 1'b0;
         thin_ack   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         dt_start   <= w_dt_start;
         hyst_start <= w_hyst_start;
         thin_ack   <= w_thin_ack;
         busy       <= w_busy;
      end
   end

   // Active threshold registers with ordering check; rejected writes flag cfg_err
   always_ff @(posedge clk) begin
      if (rst) begin
         r_act_high <= PIX_WIDTH'(DEF_HIGH);
         r_act_low  <= PIX_WIDTH'(DEF_LOW);
         cfg_err    <= 1'b0;
      end else begin
         cfg_err <= cfg_wr & ~w_cfg_ok;
         if (cfg_wr && w_cfg_ok) begin
            if (cfg_sel) r_act_high <= cfg_data;
            else         r_act_low  <= cfg_data;
         end
      end
   end

   // Shadow thresholds take the pre-write active values at frame start
   always_ff @(posedge clk) begin
      if (rst) begin
         dt_high <= PIX_WIDTH'(DEF_HIGH);
         dt_low  <= PIX_WIDTH'(DEF_LOW);
      end else if (w_latch) begin
         dt_high <= r_act_high;
         dt_low  <= r_act_low;
      end
   end

   // Watchdog: cleared entering a wait state, counts while waiting
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wd_cnt <= '0;
      end else if (w_wd_clr) begin
         r_wd_cnt <= '0;
      end else if (w_wd_run) begin
         r_wd_cnt <= r_wd_cnt + WD_WIDTH'(1);
      end
   end

   // Frame counter, sticky timeout flag, drop flag and dual_val edge history
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt   <= '0;
         timeout_err <= 1'b0;
         r_drop      <= 1'b0;
         r_dual_q    <= 1'b0;
      end else begin
         r_dual_q <= dual_val;
         if (w_timeout) begin
            timeout_err <= 1'b1;
            r_drop      <= 1'b1;
         end else if (r_state == S_DONE) begin
            r_drop <= 1'b0;
         end
         if (w_count) begin
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_threshold_ctrl.sv
// Self-checking bench for threshold_ctrl: directed scenarios followed by
// randomized frames, checked against a frame-level reference model.
module tb_threshold_ctrl;

   localparam int unsigned PW = 8;
   localparam int unsigned CW = 2;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_wr;
   logic          cfg_sel;
   logic [PW-1:0] cfg_data;
   logic          cfg_err;
   logic          thin_val;
   logic          thin_ack;
   logic          dt_start;
   logic [PW-1:0] dt_high;
   logic [PW-1:0] dt_low;
   logic          dual_val;
   logic          hyst_start;
   logic          hyst_done;
   logic          busy;
   logic [CW-1:0] frame_cnt;
   logic          timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int m_h, m_l, m_cnt;
   bit m_toe;

   threshold_ctrl #(
      .PIX_WIDTH(PW), .DEF_HIGH(100), .DEF_LOW(50), .TIMEOUT(TO), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .thin_val(thin_val), .thin_ack(thin_ack), .dt_start(dt_start),
      .dt_high(dt_high), .dt_low(dt_low), .dual_val(dual_val), .hyst_start(hyst_start),
      .hyst_done(hyst_done), .busy(busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_h   = 100;
      m_l   = 50;
      m_cnt = 0;
      m_toe = 1'b0;
   endtask

   // HIGH must stay >= LOW; a write breaking that is rejected
   task automatic model_wr(input bit sel, input int d, output bit err);
      if (sel) err = (d < m_l);
      else     err = (d > m_h);
      if (!err) begin
         if (sel) m_h = d;
         else     m_l = d;
      end
   endtask

   task automatic do_write(input bit sel, input int d);
      bit e;
      cfg_wr   = 1'b1;
      cfg_sel  = sel;
      cfg_data = 8'(d);
      model_wr(sel, d, e);
      tick();
      cfg_wr = 1'b0;
      chk("cfg_err", 32'(cfg_err), 32'(e));
   endtask

   // One frame from IDLE back to IDLE
   task automatic run_frame(input bit hold, input bit to,
                            input bit sw, input bit sw_sel, input int sw_d,
                            input bit mw, input bit mw_sel, input int mw_d,
                            input int d1, input int d2);
      int sh, sl;
      bit e;
      sh = m_h;
      sl = m_l;
      e  = 1'b0;
      thin_val = 1'b1;
      if (sw) begin
         cfg_wr   = 1'b1;
         cfg_sel  = sw_sel;
         cfg_data = 8'(sw_d);
         model_wr(sw_sel, sw_d, e);
      end
      tick();
      cfg_wr = 1'b0;
      chk("dt_start_hi", 32'(dt_start), 1);
      chk("busy_start", 32'(busy), 1);
      chk("dt_high_latch", 32'(dt_high), 32'(sh));
      chk("dt_low_latch", 32'(dt_low), 32'(sl));
      if (sw) chk("cfg_err_samecyc", 32'(cfg_err), 32'(e));
      if (!hold) thin_val = 1'b0;
      tick();
      chk("dt_start_pulse", 32'(dt_start), 0);
      if (mw) do_write(mw_sel, mw_d);
      if (to) begin
         repeat (int'(TO) - 1 - (mw ? 1 : 0)) tick();
         chk("wd_not_early", 32'(thin_ack), 0);
         tick();
         chk("wd_ack", 32'(thin_ack), 1);
         chk("wd_timeout_err", 32'(timeout_err), 1);
         m_toe = 1'b1;
      end else begin
         repeat (d1) tick();
         dual_val = 1'b1;
         tick();
         chk("hyst_start_hi", 32'(hyst_start), 1);
         dual_val = 1'b0;
         tick();
         chk("hyst_start_pulse", 32'(hyst_start), 0);
         chk("ack_early", 32'(thin_ack), 0);
         repeat (d2) tick();
         hyst_done = 1'b1;
         tick();
         hyst_done = 1'b0;
         chk("thin_ack_hi", 32'(thin_ack), 1);
         m_cnt = (m_cnt + 1) % (1 << CW);
      end
      chk("busy_done", 32'(busy), 1);
      chk("dt_high_stable", 32'(dt_high), 32'(sh));
      chk("dt_low_stable", 32'(dt_low), 32'(sl));
      tick();
      chk("thin_ack_pulse", 32'(thin_ack), 0);
      chk("busy_idle", 32'(busy), 0);
      chk("dt_start_idle", 32'(dt_start), 0);
      chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      chk("timeout_err", 32'(timeout_err), 32'(m_toe));
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(thin_ack), 0);
      chk("rst_dt_start", 32'(dt_start), 0);
      chk("rst_hyst_start", 32'(hyst_start), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);
      chk("rst_frame_cnt", 32'(frame_cnt), 0);
      chk("rst_dt_high", 32'(dt_high), 100);
      chk("rst_dt_low", 32'(dt_low), 50);
      rst = 1'b0;
      model_reset();
      tick();
   endtask

   initial begin
      bit prev_hold;
      rst = 1'b1; cfg_wr = 1'b0; cfg_sel = 1'b0; cfg_data = '0;
      thin_val = 1'b0; dual_val = 1'b0; hyst_done = 1'b0;
      tick();
      apply_reset();

      // basic frame with defaults
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);

      // config validation
      do_write(1, 40);
      tick();
      chk("cfg_err_pulse", 32'(cfg_err), 0);
      do_write(0, 30);
      do_write(1, 40);
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

      // mid-frame write affects only the next frame
      run_frame(0, 0, 0, 0, 0, 1, 1, 200, 3, 0);
      chk("mw_model", 32'(m_h), 200);
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

      // write coincident with frame start: shadow takes pre-write value
      run_frame(0, 0, 1, 0, 60, 0, 0, 0, 1, 1);
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);

      // stray completion pulses in IDLE are ignored
      dual_val = 1'b1; hyst_done = 1'b1;
      tick();
      dual_val = 1'b0; hyst_done = 1'b0;
      tick();
      chk("stray_busy", 32'(busy), 0);
      chk("stray_hyst_start", 32'(hyst_start), 0);
      chk("stray_ack", 32'(thin_ack), 0);

      // watchdog, then a normal frame with the sticky flag still set
      run_frame(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 4, 4);

      // back-to-back frames with counter wrap from reset: 1,2,3,0
      apply_reset();
      run_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run_frame(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      run_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
      chk("wrap_cnt", 32'(frame_cnt), 0);

      // reset mid-frame in WAIT_HY
      do_write(1, 220);
      thin_val = 1'b1;
      tick();
      thin_val = 1'b0;
      tick();
      dual_val = 1'b1;
      tick();
      dual_val = 1'b0;
      tick();
      chk("mid_busy", 32'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_ack", 32'(thin_ack), 0);
      chk("mid_rst_cnt", 32'(frame_cnt), 0);
      chk("mid_rst_dt_high", 32'(dt_high), 100);
      chk("mid_rst_hyst_start", 32'(hyst_start), 0);
      hyst_done = 1'b1;
      tick();
      hyst_done = 1'b0;
      chk("late_done_ack", 32'(thin_ack), 0);
      chk("late_done_busy", 32'(busy), 0);
      tick();
      chk("late_done_ack2", 32'(thin_ack), 0);
      run_frame(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

      // randomized frames
      prev_hold = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bit hold, to, sw, mw;
         hold = 1'($urandom_range(0, 1));
         to   = ($urandom_range(0, 7) == 0);
         sw   = 1'($urandom_range(0, 1));
         mw   = 1'($urandom_range(0, 1));
         if (!prev_hold) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++)
               do_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
         end
         run_frame(hold, to, sw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                   mw, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
         prev_hold = hold;
      end
      thin_val = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
